// File: rtl/hilo_muldiv_if.sv
// Execute-stage <-> hi/lo multiply/divide unit bundle.
// start/busy: start is taken on a rising edge only when busy=0 and flush=0; done pulses one cycle with hi/lo already valid.
interface hilo_muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  dbg_state;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo, dbg_state
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo, dbg_state
   );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the MIPS hi/lo registers.
// Multiply takes one compute cycle; divide is restoring radix-2 over DIV_ITERS cycles.
module hilo_muldiv #(
   parameter int DIV_ITERS = 32
) (
   input logic          clk,
   input logic          resetn,
   hilo_muldiv_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int CW = $clog2(DIV_ITERS);
   localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    op_q;
   logic [31:0]   a_q, b_q, rem, quot, hi_q, lo_q;
   logic          q_neg, r_neg;

   logic          is_div_s;
   logic [31:0]   a_abs, b_abs;
   logic          sx;
   logic [63:0]   prod;
   logic [32:0]   rem_sh;
   logic [33:0]   diff;
   logic          fits;
   logic [31:0]   rem_nx, quot_nx, q_fin, r_fin;

   // Operand conditioning at accept: signed divide works on magnitudes.
   always_comb begin
      is_div_s = (bus.op == 2'd2);
      a_abs    = (is_div_s && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
      b_abs    = (is_div_s && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
   end

   always_comb begin
      sx   = ~op_q[0];
      prod = {{32{sx & a_q[31]}}, a_q} * {{32{sx & b_q[31]}}, b_q};
   end

   // One restoring step: shift {rem,quot} left, trial-subtract divisor.
   always_comb begin
      rem_sh  = {rem, quot[31]};
      diff    = {1'b0, rem_sh} - {2'b00, b_q};
      fits    = ~diff[33];
      rem_nx  = fits ? diff[31:0] : rem_sh[31:0];
      quot_nx = {quot[30:0], fits};
      q_fin   = q_neg ? (32'd0 - quot_nx) : quot_nx;
      r_fin   = r_neg ? (32'd0 - rem_nx) : rem_nx;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= 2'd0;
         a_q   <= '0;
         b_q   <= '0;
         rem   <= '0;
         quot  <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else if (bus.flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  op_q  <= bus.op;
                  a_q   <= bus.a;
                  b_q   <= bus.op[1] ? b_abs : bus.b;
                  quot  <= a_abs;
                  rem   <= '0;
                  q_neg <= is_div_s & (bus.a[31] ^ bus.b[31]);
                  r_neg <= is_div_s & bus.a[31];
                  cnt   <= '0;
                  state <= bus.op[1] ? S_DIV : S_MUL;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               hi_q  <= prod[63:32];
               lo_q  <= prod[31:0];
               state <= S_DONE;
            end
            S_DIV: begin
               rem  <= rem_nx;
               quot <= quot_nx;
               if (cnt == LAST) begin
                  // Zero divisor still runs full length; result is fixed, not computed.
                  if (b_q == 32'd0) begin
                     hi_q <= a_q;
                     lo_q <= 32'hFFFF_FFFF;
                  end else begin
                     hi_q <= r_fin;
                     lo_q <= q_fin;
                  end
                  cnt   <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = (state == S_MUL) || (state == S_DIV);
   assign bus.done      = (state == S_DONE);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.dbg_state = state;
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit for the execute stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operands from execute, computes the 64-bit product or the quotient/remainder, and holds the result in its hi/lo registers. Execute reads hi/lo from here to fill the `hi`/`lo` fields of `execute_data_t`. While an operation is in flight, `busy` stalls the pipeline.

## Interface
Parameters:
- DIV_ITERS, 32, radix-2 divide iterations; must equal the word width.

Ports (`word_t` = 32 bits):
- clk  in  1  pipeline clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation this cycle.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- a  in  32  rs operand: multiplicand or dividend.
- b  in  32  rt operand: multiplier or divisor.
- flush  in  1  abort any in-flight operation (exception or branch flush).
- busy  out  1  operation in progress; execute stalls while high.
- done  out  1  one-cycle pulse; hi/lo were updated at this cycle's start.
- hi  out  32  remainder (divide) or product[63:32] (multiply).
- lo  out  32  quotient (divide) or product[31:0] (multiply).

## Operation
- States:
  - IDLE: no operation.
  - MUL: one compute cycle.
  - DIV: iterate, counter 0..DIV_ITERS-1.
  - DONE: result pulse.
- IDLE or DONE with start=1 and flush=0:
  - Latch op.
  - Latch |a| and |b| for DIV, raw values for DIVU.
  - Record dividend sign and quotient sign (sign(a) XOR sign(b)) for DIV.
  - Go to MUL for ops 0/1, DIV for ops 2/3.
- IDLE or DONE with start=0: go to IDLE.
- MUL:
  - Product is 64 bits: signed×signed for MULT, unsigned×unsigned for MULTU.
  - Write hi/lo, then go to DONE.
- DIV:
  - Restoring division: each cycle shift the {rem, quot} pair left 1, trial-subtract the divisor, and set the quotient bit if no borrow.
  - When the counter reaches DIV_ITERS-1, apply signs and write hi/lo, then go to DONE.
  - DIV signs: quotient is negated if the quotient sign is set; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap).
  - Divisor zero (both DIV and DIVU): full latency; result hi=a as latched (original signed value), lo=0xFFFFFFFF.
- Output decode:
  - busy = (state==MUL or state==DIV).
  - done = (state==DONE).
  - hi/lo are registers and change only when MUL/DIV finishes.
- start while busy: ignored.
- flush:
  - Any state goes to IDLE next cycle.
  - hi/lo unchanged; no done pulse.
  - flush and start in the same cycle: flush wins; the start is dropped.
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, counter=0.
  - hi=lo=0, busy=0, done=0.

## Timing
- start accepted at edge T:
  - MUL: busy=1 during [T, T+1). hi/lo valid and done=1 during [T+1, T+2).
  - DIV: busy=1 for DIV_ITERS cycles. done=1 and hi/lo valid in cycle T+DIV_ITERS (33rd cycle after accept).
- A new start during the DONE cycle is accepted: back-to-back operations with no idle bubble.
- Execute may sample hi/lo combinationally in the done cycle; there is no extra forwarding latency.
- The busy to stall path is combinational from the state register only (no input-to-output path).

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7:
  - done one cycle after accept.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001.
  - Immediately follow with MULT 2×3 in the done cycle; next pulse gives hi=0, lo=6.
- DIVU a=100, b=7:
  - busy for 32 cycles, then done.
  - lo=0x0E, hi=0x02.
- DIV a=-7, b=2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=-1:
  - lo=0x80000000, hi=0.
- Divide by zero:
  - DIV a=0x12345678, b=0: hi=0x12345678, lo=0xFFFFFFFF after full latency.
- Abort cases:
  - DIVU 100/7 with flush on iteration 10: busy drops next cycle, no done, hi/lo keep the prior values.
  - Repeat with resetn pulsed low mid-divide: busy=0, hi=lo=0 immediately.
  - A following start in either case completes correctly.
